// File: rtl/stream_rf_pkg.sv
// Shared defaults, typedefs and controller state encoding for the stream register file.
package stream_rf_pkg;

   localparam int NUM_STREAMS_DEF  = 32;
   localparam int NUM_TILES_DEF    = 20;
   localparam int VEC_W_DEF        = 16;
   localparam int NUM_RD_PORTS_DEF = 2;
   localparam int ID_W_DEF         = $clog2(NUM_STREAMS_DEF);

   typedef logic [ID_W_DEF-1:0]                     stream_id_t;
   typedef logic [NUM_TILES_DEF-1:0][VEC_W_DEF-1:0] tile_vec_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } rf_state_e;

endpackage

// File: rtl/stream_rf_init_ctrl.sv
// Clear sequencer: walks every stream once after reset or a clear request.
//   state   | meaning
//   ST_INIT | zeroing stream clr_idx this cycle; no traffic accepted
//   ST_IDLE | normal operation; clear_req starts a new sweep
module stream_rf_init_ctrl
   import stream_rf_pkg::*;
#(
   parameter  int NUM_STREAMS = NUM_STREAMS_DEF,
   localparam int ID_W        = $clog2(NUM_STREAMS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear_req,
   output logic            init_busy,
   output logic            clr_en,
   output logic [ID_W-1:0] clr_idx,
   output logic            clr_go
);

   rf_state_e       state_q, state_d;
   logic [ID_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_go  = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == ID_W'(NUM_STREAMS - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               clr_go  = 1'b1;
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign init_busy = (state_q == ST_INIT);
   assign clr_en    = init_busy;
   assign clr_idx   = cnt_q;

endmodule

// File: rtl/stream_reg_file_mp.sv
// Multi-port stream register file: masked tile writes, 1-cycle reads with write-first bypass.
module stream_reg_file_mp
   import stream_rf_pkg::*;
#(
   parameter  int NUM_STREAMS  = NUM_STREAMS_DEF,
   parameter  int NUM_TILES    = NUM_TILES_DEF,
   parameter  int VEC_W        = VEC_W_DEF,
   parameter  int NUM_RD_PORTS = NUM_RD_PORTS_DEF,
   localparam int ID_W         = $clog2(NUM_STREAMS)
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             clear_req,
   output logic                                             init_busy,
   input  logic                                             wr_valid,
   output logic                                             wr_ready,
   input  logic [ID_W-1:0]                                  wr_stream_id,
   input  logic [NUM_TILES-1:0]                             wr_tile_mask,
   input  logic [NUM_TILES-1:0][VEC_W-1:0]                  wr_data,
   input  logic [NUM_RD_PORTS-1:0]                          rd_valid,
   output logic [NUM_RD_PORTS-1:0]                          rd_ready,
   input  logic [NUM_RD_PORTS-1:0][ID_W-1:0]                rd_stream_id,
   output logic [NUM_RD_PORTS-1:0]                          rd_data_valid,
   output logic [NUM_RD_PORTS-1:0][NUM_TILES-1:0][VEC_W-1:0] rd_data,
   output logic [NUM_STREAMS-1:0]                           stream_written
);

   logic [NUM_TILES-1:0][VEC_W-1:0]                  mem_q [NUM_STREAMS];
   logic [NUM_STREAMS-1:0]                           written_q, written_d;
   logic [NUM_RD_PORTS-1:0]                          rd_valid_q, rd_valid_d;
   logic [NUM_RD_PORTS-1:0][NUM_TILES-1:0][VEC_W-1:0] rd_data_q, rd_data_d;
   logic [NUM_TILES-1:0][VEC_W-1:0]                  rd_vec;
   logic                                             clr_en, clr_go, wr_fire;
   logic [ID_W-1:0]                                  clr_idx;

   stream_rf_init_ctrl #(.NUM_STREAMS(NUM_STREAMS)) u_init_ctrl (
      .clk       (clk),
      .rst       (rst),
      .clear_req (clear_req),
      .init_busy (init_busy),
      .clr_en    (clr_en),
      .clr_idx   (clr_idx),
      .clr_go    (clr_go)
   );

   assign wr_ready = ~init_busy;
   assign rd_ready = {NUM_RD_PORTS{~init_busy}};
   assign wr_fire  = wr_valid & wr_ready;

   // Storage has no reset; the INIT sweep is what zeroes it.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem_q[clr_idx] <= '0;
      end else if (wr_fire) begin
         for (int t = 0; t < NUM_TILES; t++) begin
            if (wr_tile_mask[t]) mem_q[wr_stream_id][t] <= wr_data[t];
         end
      end
   end

   // A clear wins over a same-cycle write when updating the written flags.
   always_comb begin
      written_d = written_q;
      if (clr_go)       written_d = '0;
      else if (wr_fire) written_d[wr_stream_id] = 1'b1;
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = '0;
      rd_vec     = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         rd_vec = written_q[rd_stream_id[p]] ? mem_q[rd_stream_id[p]] : '0;
         if (wr_fire && (wr_stream_id == rd_stream_id[p])) begin
            for (int t = 0; t < NUM_TILES; t++) begin
               if (wr_tile_mask[t]) rd_vec[t] = wr_data[t];
            end
         end
         rd_valid_d[p] = rd_valid[p] & rd_ready[p];
         if (rd_valid_d[p]) rd_data_d[p] = rd_vec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         written_q  <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         written_q  <= written_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_data_valid  = rd_valid_q;
   assign rd_data        = rd_data_q;
   assign stream_written = written_q;

endmodule

// File: tb/tb_stream_reg_file_mp.sv
// Directed bench for stream_reg_file_mp with a read-result scoreboard per port.
module tb_stream_reg_file_mp;
   import stream_rf_pkg::*;

   localparam int NS = 32;
   localparam int NT = 20;
   localparam int VW = 16;
   localparam int NP = 2;
   localparam int IW = 5;
   localparam int TW = NT * VW;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic                          clear_req = 1'b0;
   logic                          init_busy;
   logic                          wr_valid = 1'b0;
   logic                          wr_ready;
   logic [IW-1:0]                 wr_stream_id = '0;
   logic [NT-1:0]                 wr_tile_mask = '0;
   logic [NT-1:0][VW-1:0]         wr_data = '0;
   logic [NP-1:0]                 rd_valid = '0;
   logic [NP-1:0]                 rd_ready;
   logic [NP-1:0][IW-1:0]         rd_stream_id = '0;
   logic [NP-1:0]                 rd_data_valid;
   logic [NP-1:0][NT-1:0][VW-1:0] rd_data;
   logic [NS-1:0]                 stream_written;

   stream_reg_file_mp dut (
      .clk            (clk),
      .rst            (rst),
      .clear_req      (clear_req),
      .init_busy      (init_busy),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_stream_id   (wr_stream_id),
      .wr_tile_mask   (wr_tile_mask),
      .wr_data        (wr_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_stream_id   (rd_stream_id),
      .rd_data_valid  (rd_data_valid),
      .rd_data        (rd_data),
      .stream_written (stream_written)
   );

   always #5 clk = ~clk;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [TW-1:0] m_mem [NS];
   logic [NS-1:0] m_wr;
   logic [TW-1:0] exp_q0 [$];
   logic [TW-1:0] exp_q1 [$];
   logic [NP-1:0] pend = '0;
   logic [TW-1:0] last0 = '0;
   logic [TW-1:0] last1 = '0;
   tile_vec_t     tv;
   int            n;

   task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [TW-1:0] ramp(input logic [VW-1:0] base);
      logic [TW-1:0] v;
      for (int i = 0; i < NT; i++) v[i*VW +: VW] = base + VW'(i);
      return v;
   endfunction

   task automatic model_clear();
      m_wr = '0;
      for (int s = 0; s < NS; s++) m_mem[s] = '0;
   endtask

   task automatic do_write(input int id, input logic [NT-1:0] mask, input logic [TW-1:0] data);
      wr_valid     = 1'b1;
      wr_stream_id = IW'(id);
      wr_tile_mask = mask;
      wr_data      = data;
      for (int t = 0; t < NT; t++)
         if (mask[t]) m_mem[id][t*VW +: VW] = data[t*VW +: VW];
      m_wr[id] = 1'b1;
   endtask

   task automatic do_read(input int p, input int id);
      logic [TW-1:0] e;
      rd_valid[p]     = 1'b1;
      rd_stream_id[p] = IW'(id);
      e = m_wr[id] ? m_mem[id] : '0;
      if (p == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      pend[p] = 1'b1;
   endtask

   task automatic tick();
      logic [TW-1:0] e;
      @(posedge clk);
      #1;
      wr_valid     = 1'b0;
      wr_tile_mask = '0;
      rd_valid     = '0;
      clear_req    = 1'b0;
      @(negedge clk);
      if (pend[0]) begin
         chk("rd0_valid", TW'(rd_data_valid[0]), TW'(1));
         e = exp_q0.pop_front();
         chk("rd0_data", rd_data[0], e);
         last0 = e;
      end else begin
         chk("rd0_no_valid", TW'(rd_data_valid[0]), TW'(0));
         chk("rd0_hold", rd_data[0], last0);
      end
      if (pend[1]) begin
         chk("rd1_valid", TW'(rd_data_valid[1]), TW'(1));
         e = exp_q1.pop_front();
         chk("rd1_data", rd_data[1], e);
         last1 = e;
      end else begin
         chk("rd1_no_valid", TW'(rd_data_valid[1]), TW'(0));
         chk("rd1_hold", rd_data[1], last1);
      end
      pend = '0;
   endtask

   // Counts rising edges until init_busy drops; optionally pokes clear_req mid-sweep.
   task automatic count_init(input int poke_at, output int cnt);
      cnt = 0;
      while (init_busy === 1'b1 && cnt < 100) begin
         clear_req = (cnt == poke_at);
         @(posedge clk);
         #1 clear_req = 1'b0;
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_init_busy"}, TW'(init_busy), TW'(1));
      chk({tag, "_wr_ready"}, TW'(wr_ready), TW'(0));
      chk({tag, "_rd_ready"}, TW'(rd_ready), TW'(0));
      chk({tag, "_written"}, TW'(stream_written), TW'(0));
      chk({tag, "_rd_valid"}, TW'(rd_data_valid), TW'(0));
      chk({tag, "_rd_data0"}, rd_data[0], '0);
      chk({tag, "_rd_data1"}, rd_data[1], '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      @(negedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      count_init(-1, n);
      chk("init_len", TW'(n), TW'(32));
      chk("idle_wr_ready", TW'(wr_ready), TW'(1));
      chk("idle_rd_ready", TW'(rd_ready), TW'(2'b11));
      chk("idle_written", TW'(stream_written), TW'(0));

      // Full write then read on port 0
      do_write(0, '1, ramp(16'd1));
      tick();
      chk("wr0_flag", TW'(stream_written[0]), TW'(1));
      do_read(0, 0);
      tick();
      chk("rd0_tile19", TW'(rd_data[0][19]), TW'(16'd20));

      // Masked write with same-cycle read on port 1 (bypass)
      do_write(4, '1, ramp(16'h000A));
      tick();
      tv = '1;
      do_write(4, 20'h00003, TW'(tv));
      do_read(1, 4);
      tick();
      chk("byp_tile0", TW'(rd_data[1][0]), TW'(16'hFFFF));
      chk("byp_tile1", TW'(rd_data[1][1]), TW'(16'hFFFF));
      chk("byp_tile2", TW'(rd_data[1][2]), TW'(16'h000C));
      do_read(0, 4);
      do_read(1, 4);
      tick();
      chk("same_stream_both", rd_data[0], rd_data[1]);
      tick();

      // Never-written stream on both ports
      do_read(0, 7);
      do_read(1, 7);
      tick();
      chk("unwr_flag7", TW'(stream_written[7]), TW'(0));
      chk("unwr_data0", rd_data[0], '0);

      // Zero-mask write: accepted, flag set, data unchanged
      do_write(9, '0, ramp(16'h1234));
      tick();
      chk("mask0_flag9", TW'(stream_written[9]), TW'(1));
      do_read(0, 9);
      tick();

      // Clear sequence; clear_req during INIT must be ignored
      do_write(3, '1, ramp(16'h0300));
      tick();
      clear_req = 1'b1;
      do_read(0, 3);
      tick();
      model_clear();
      chk("clr_busy", TW'(init_busy), TW'(1));
      chk("clr_written", TW'(stream_written), TW'(0));
      chk("clr_wr_ready", TW'(wr_ready), TW'(0));
      count_init(5, n);
      chk("clr_len", TW'(n), TW'(32));
      do_read(0, 3);
      do_read(1, 0);
      tick();
      chk("clr_rd3_zero", rd_data[0], '0);

      // Reset mid-operation, then again on INIT cycle 10
      do_write(5, '1, ramp(16'h0055));
      tick();
      do_read(0, 5);
      tick();
      rst = 1'b1;
      #1;
      model_clear();
      last0 = '0;
      last1 = '0;
      chk_reset_outputs("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("init10_busy", TW'(init_busy), TW'(1));
      rst = 1'b1;
      #1;
      chk("rst_init10_busy", TW'(init_busy), TW'(1));
      @(negedge clk);
      rst = 1'b0;
      count_init(-1, n);
      chk("rst_init_len", TW'(n), TW'(32));
      do_read(1, 5);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_reg_file_mp.md
STREAM_REG_FILE_MP -- requirements
Module: stream_reg_file_mp

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 32: number of stream registers.
REQ-002 SHALL have parameter NUM_TILES, default 20: tiles per vector slice.
REQ-003 SHALL have parameter VEC_W, default 16: bits per tile element.
REQ-004 SHALL have parameter NUM_RD_PORTS, default 2: independent read ports.
REQ-005 SHALL derive ID_W = $clog2(NUM_STREAMS) as a localparam.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port clear_req, input, 1: request to zero all streams.
REQ-009 SHALL have port init_busy, output, 1: high while the clear sequence runs.
REQ-010 SHALL have port wr_valid, input, 1: write request.
REQ-011 SHALL have port wr_ready, output, 1: write can be accepted.
REQ-012 SHALL have port wr_stream_id, input, ID_W: destination stream.
REQ-013 SHALL have port wr_tile_mask, input, NUM_TILES: per-tile write enable.
REQ-014 SHALL have port wr_data, input, NUM_TILES x VEC_W packed: write vector.
REQ-015 SHALL have port rd_valid, input, NUM_RD_PORTS: per-port read request.
REQ-016 SHALL have port rd_ready, output, NUM_RD_PORTS: per-port read can be accepted.
REQ-017 SHALL have port rd_stream_id, input, NUM_RD_PORTS x ID_W: source stream per port.
REQ-018 SHALL have port rd_data_valid, output, NUM_RD_PORTS: rd_data of that port is new this cycle.
REQ-019 SHALL have port rd_data, output, NUM_RD_PORTS x NUM_TILES x VEC_W: read vectors.
REQ-020 SHALL have port stream_written, output, NUM_STREAMS: per-stream written-since-clear flag.

Function
REQ-021 SHALL implement FSM states INIT and IDLE only.
REQ-022 In INIT, SHALL zero all tiles of one stream per cycle, counter 0 to NUM_STREAMS-1, then enter IDLE; total NUM_STREAMS cycles.
REQ-023 SHALL drive init_busy=1, wr_ready=0 and rd_ready=all-0 in INIT; all 1 in IDLE.
REQ-024 SHALL accept a write when wr_valid && wr_ready; updates only tiles whose wr_tile_mask bit is 1; sets stream_written[wr_stream_id].
REQ-025 SHALL treat a write with wr_tile_mask=0 as accepted, with no data change, but still setting stream_written.
REQ-026 SHALL accept read port p when rd_valid[p] && rd_ready[p].
REQ-027 Read latency SHALL be 1 cycle: rd_data[p] and rd_data_valid[p]=1 are driven in the cycle after acceptance.
REQ-028 rd_data_valid[p] SHALL be 0 in cycles without a preceding acceptance; rd_data[p] SHALL hold its last value.
REQ-029 On a same-cycle write and read of the same stream, the read SHALL return the merged vector: new data on masked tiles, old data elsewhere (write-first bypass).
REQ-030 Multiple ports reading the same stream in one cycle SHALL all receive identical data.
REQ-031 Reading a stream whose stream_written bit is 0 SHALL return all-zero data.
REQ-032 clear_req SHALL be sampled only in IDLE; that cycle's accepted write and reads SHALL complete, then the FSM enters INIT next cycle with stream_written cleared to 0.
REQ-033 clear_req SHALL be ignored while in INIT.

Reset
REQ-034 rst=1 SHALL asynchronously set state=INIT, counter=0, stream_written=0, rd_data_valid=0, rd_data=0, init_busy=1.
REQ-035 Storage SHALL NOT be asynchronously reset; zeroing occurs through the INIT sequence after rst deasserts.
REQ-036 Assertion of rst mid-INIT or mid-read SHALL abort the operation; the INIT sequence restarts from stream 0.

Structure
REQ-037 Package stream_rf_pkg SHALL hold the default parameters, the stream_id_t and tile_vec_t typedefs, and the state enum.
REQ-038 Sub-module stream_rf_init_ctrl SHALL contain the FSM, the clear counter and the clear_req handling.

Verification
REQ-039 Reset, then count cycles until init_busy falls -> exactly 32 cycles; wr_ready=1; stream_written=0.
REQ-040 Write stream 0 with tile i = i+1 and mask all-1s; next cycle read stream 0 on port 0 -> one cycle later rd_data_valid[0]=1 and tile i = i+1.
REQ-041 Stream 4 holds 0x000A+i; write 0xFFFF with mask 0x00003 while port 1 reads stream 4 in the same cycle -> tiles 0-1 = 0xFFFF, tile 2 = 0x000C.
REQ-042 Both ports read stream 7, which has never been written -> both return all-zero and stream_written[7]=0.
REQ-043 After writing stream 3, pulse clear_req -> init_busy high for 32 cycles; a subsequent read of stream 3 returns zero.
REQ-044 Assert rst on INIT cycle 10 -> after release, init_busy stays high for a full 32 cycles.
